// File: rtl/hazard_stall_unit.sv
// D-stage hazard controller: Tuse/Tnew data-hazard stall, HI/LO busy tracking,
// stall cause reporting and a saturating stalled-cycle counter.
module hazard_stall_unit #(
    parameter int RA_W        = 5,
    parameter int TUSE_W      = 3,
    parameter int TNEW_LOAD_E = 2,
    parameter int TNEW_CALC_E = 1,
    parameter int TNEW_LOAD_M = 1,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        type_e,
    input  logic [1:0]        type_m,
    input  logic [RA_W-1:0]   a1_d,
    input  logic [RA_W-1:0]   a2_d,
    input  logic [RA_W-1:0]   a3_e,
    input  logic [RA_W-1:0]   a3_m,
    input  logic              we_e,
    input  logic              we_m,
    input  logic [TUSE_W-1:0] tuse_rs_d,
    input  logic [TUSE_W-1:0] tuse_rt_d,
    input  logic              md_d,
    input  logic              md_start_e,
    input  logic              md_is_div_e,
    output logic              stall,
    output logic [1:0]        stall_cause,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int         MD_W   = $clog2(DIV_CYCLES + 1);
    localparam logic [1:0] T_CALC = 2'b01;
    localparam logic [1:0] T_LOAD = 2'b10;

    logic [TUSE_W-1:0] w_tnew_e;
    logic [TUSE_W-1:0] w_tnew_m;
    logic [TUSE_W-1:0] w_tuse [2];
    logic [RA_W-1:0]   w_a_d  [2];
    logic [3:0]        w_hz_term;
    logic              w_data_hz;
    logic              w_md_hz;
    logic              w_stall;

    logic [MD_W-1:0]   r_md_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Class 2'b11 falls through to Tnew 0, same as "none".
    always_comb begin
        w_tnew_e = '0;
        if (type_e == T_LOAD) begin
            w_tnew_e = TUSE_W'(TNEW_LOAD_E);
        end else if (type_e == T_CALC) begin
            w_tnew_e = TUSE_W'(TNEW_CALC_E);
        end
    end

    assign w_tnew_m = (type_m == T_LOAD) ? TUSE_W'(TNEW_LOAD_M) : '0;

    assign w_tuse[0] = tuse_rs_d;
    assign w_tuse[1] = tuse_rt_d;
    assign w_a_d[0]  = a1_d;
    assign w_a_d[1]  = a2_d;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_hz_term[gi*2]   = (w_tuse[gi] < w_tnew_e) && we_e &&
                                       (w_a_d[gi] == a3_e) && (a3_e != '0);
            assign w_hz_term[gi*2+1] = (w_tuse[gi] < w_tnew_m) && we_m &&
                                       (w_a_d[gi] == a3_m) && (a3_m != '0);
        end
    endgenerate

    assign w_data_hz = |w_hz_term;
    // The start cycle itself already blocks MD issue, before md_cnt loads.
    assign w_md_hz   = md_d && (md_busy || md_start_e);
    assign w_stall   = w_data_hz || w_md_hz;

    // A start while still busy simply reloads the countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (md_start_e) begin
            r_md_cnt <= md_is_div_e ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign md_busy     = (r_md_cnt != '0);
    assign stall       = w_stall;
    assign stall_cause = {w_md_hz, w_data_hz};
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; a second instance with a 3-bit
// counter shares the stimulus to exercise saturation.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  type_e, type_m;
    logic [4:0]  a1_d, a2_d, a3_e, a3_m;
    logic        we_e, we_m;
    logic [2:0]  tuse_rs_d, tuse_rt_d;
    logic        md_d, md_start_e, md_is_div_e;
    logic        stall, md_busy;
    logic [1:0]  stall_cause;
    logic [31:0] stall_cnt;
    logic        s_stall, s_md_busy;
    logic [1:0]  s_stall_cause;
    logic [2:0]  s_stall_cnt;

    int n_pass  = 0;
    int n_check = 0;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk(clk), .reset(reset), .type_e(type_e), .type_m(type_m),
        .a1_d(a1_d), .a2_d(a2_d), .a3_e(a3_e), .a3_m(a3_m),
        .we_e(we_e), .we_m(we_m), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .md_d(md_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
        .stall(stall), .stall_cause(stall_cause), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    hazard_stall_unit #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .type_e(type_e), .type_m(type_m),
        .a1_d(a1_d), .a2_d(a2_d), .a3_e(a3_e), .a3_m(a3_m),
        .we_e(we_e), .we_m(we_m), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .md_d(md_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
        .stall(s_stall), .stall_cause(s_stall_cause), .md_busy(s_md_busy),
        .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        type_e = 2'b00; type_m = 2'b00;
        a1_d = '0; a2_d = '0; a3_e = '0; a3_m = '0;
        we_e = 1'b0; we_m = 1'b0;
        tuse_rs_d = 3'd0; tuse_rt_d = 3'd0;
        md_d = 1'b0; md_start_e = 1'b0; md_is_div_e = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_cause", 32'(stall_cause), 32'd0);
        reset = 1'b0;

        // Load-use in E: Tnew 2
        @(negedge clk);
        type_e = 2'b10; we_e = 1'b1; a3_e = 5'd5; a1_d = 5'd5;
        tuse_rs_d = 3'd1; tuse_rt_d = 3'd7;
        #1;
        check("load_use_stall", 32'(stall), 32'd1);
        check("load_use_cause", 32'(stall_cause), 32'd1);
        tuse_rs_d = 3'd2; #1;
        check("load_use_tuse2", 32'(stall), 32'd0);
        tuse_rs_d = 3'd7; #1;
        check("tuse_unused", 32'(stall), 32'd0);

        // Calc in E (Tnew 1) against rt, and class 2'b11 treated as none
        @(negedge clk);
        clear_inputs();
        type_e = 2'b01; we_e = 1'b1; a3_e = 5'd3; a2_d = 5'd3;
        tuse_rs_d = 3'd7; tuse_rt_d = 3'd0;
        #1;
        check("calc_e_rt", 32'(stall), 32'd1);
        type_e = 2'b11; #1;
        check("type11_none", 32'(stall), 32'd0);
        type_e = 2'b01; we_e = 1'b0; #1;
        check("calc_e_no_we", 32'(stall), 32'd0);

        // M stage and register 0
        @(negedge clk);
        clear_inputs();
        type_m = 2'b10; we_m = 1'b1; a3_m = 5'd0; a2_d = 5'd0;
        tuse_rs_d = 3'd7; tuse_rt_d = 3'd0;
        #1;
        check("reg0_no_stall", 32'(stall), 32'd0);
        a3_m = 5'd9; a2_d = 5'd9; #1;
        check("load_m_stall", 32'(stall), 32'd1);
        type_m = 2'b01; #1;
        check("calc_m_no_stall", 32'(stall), 32'd0);

        // Multiply: 6 stalled cycles, 5 busy cycles
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        md_d = 1'b1; md_start_e = 1'b1; md_is_div_e = 1'b0;
        #1;
        check("mult_start_stall", 32'(stall), 32'd1);
        check("mult_start_cause", 32'(stall_cause), 32'd2);
        check("mult_start_busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        md_start_e = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("mult_busy_%0d", i), 32'(md_busy), 32'd1);
            check($sformatf("mult_stall_%0d", i), 32'(stall), 32'd1);
            @(negedge clk);
        end
        #1;
        check("mult_done_busy", 32'(md_busy), 32'd0);
        check("mult_done_stall", 32'(stall), 32'd0);
        check("mult_stall_cnt", stall_cnt, 32'd6);

        // Divide, then reset after 4 busy cycles
        @(negedge clk);
        md_d = 1'b0; md_start_e = 1'b1; md_is_div_e = 1'b1;
        @(negedge clk);
        md_start_e = 1'b0; md_is_div_e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("div_busy_%0d", i), 32'(md_busy), 32'd1);
            @(negedge clk);
        end
        reset = 1'b1; md_d = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("div_rst_busy", 32'(md_busy), 32'd0);
        check("div_rst_cnt", stall_cnt, 32'd0);
        check("div_rst_md_stall", 32'(stall), 32'd0);

        // Reset together with a start: reset wins
        @(negedge clk);
        md_d = 1'b0; reset = 1'b1; md_start_e = 1'b1;
        @(negedge clk);
        reset = 1'b0; md_start_e = 1'b0;
        #1;
        check("rst_vs_start_busy", 32'(md_busy), 32'd0);

        // Combined causes: load hazard on rs plus MD while busy
        @(negedge clk);
        md_start_e = 1'b1;
        @(negedge clk);
        md_start_e = 1'b0;
        type_e = 2'b10; we_e = 1'b1; a3_e = 5'd5; a1_d = 5'd5;
        tuse_rs_d = 3'd1; tuse_rt_d = 3'd7; md_d = 1'b1;
        #1;
        check("combined_busy", 32'(md_busy), 32'd1);
        check("combined_cause", 32'(stall_cause), 32'd3);

        // Saturation of the 3-bit counter under a continuous data stall
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        type_e = 2'b10; we_e = 1'b1; a3_e = 5'd5; a1_d = 5'd5;
        tuse_rs_d = 3'd0; tuse_rt_d = 3'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("sat_cnt_%0d", k), 32'(s_stall_cnt), (k < 7) ? 32'(k) : 32'd7);
        end
        check("wide_cnt_10", stall_cnt, 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised D-stage hazard controller for the five-stage MIPS pipeline, the successor to the two-stage Tuse/Tnew stall checker. It keeps the Tuse/Tnew data-hazard stall and adds three things:
- a multiply/divide busy tracker, so MD-class instructions in D stall while the HI/LO unit is occupied;
- a cause vector;
- a saturating stall-cycle counter.

It sits beside the D/E pipeline register. `stall` freezes PC and F/D and injects a bubble into E.

## Interface
- `RA_W`, 5, register-address width
- `TUSE_W`, 3, width of Tuse inputs and internal Tnew
- `TNEW_LOAD_E`, 2, Tnew of a load in E
- `TNEW_CALC_E`, 1, Tnew of a calc in E
- `TNEW_LOAD_M`, 1, Tnew of a load in M
- `MULT_CYCLES`, 5, busy cycles after a mult start (≥1)
- `DIV_CYCLES`, 10, busy cycles after a div start (≥1)
- `CNT_W`, 32, stall-counter width
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `type_e`, `type_m`  in  2  instruction class in E/M: 2'b00 none, 2'b01 calc, 2'b10 load, 2'b11 treated as none
- `a1_d`, `a2_d`  in  RA_W  rs/rt read addresses in D
- `a3_e`, `a3_m`  in  RA_W  write addresses in E/M
- `we_e`, `we_m`  in  1  register-write enables in E/M
- `tuse_rs_d`, `tuse_rt_d`  in  TUSE_W  Tuse of rs/rt for the D instruction; all-ones means operand not used
- `md_d`  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- `md_start_e`  in  1  E holds a valid mult/div that starts this cycle
- `md_is_div_e`  in  1  qualifies `md_start_e`: 1 div, 0 mult
- `stall`  out  1  freeze F/D, bubble E
- `stall_cause`  out  2  bit0 data hazard, bit1 MD hazard
- `md_busy`  out  1  MD unit occupied
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles

## Operation
**Tnew.**
- E: `TNEW_LOAD_E` for a load, `TNEW_CALC_E` for a calc, else 0.
- M: `TNEW_LOAD_M` for a load, else 0.
- All Tnew values are zero-extended to TUSE_W.

**Data hazard.** For X in {rs, rt} and stage S in {E, M}, the hazard is raised when all of:
- Tuse_X < Tnew_S (unsigned),
- we_S = 1,
- a_X_d = a3_S,
- a3_S ≠ 0.

`data_hz` is the OR of the four terms. Register 0 never stalls.

**MD busy counter.** `md_cnt` is ceil(log2(DIV_CYCLES+1)) bits wide.
- Each cycle with `md_start_e` = 1: load `DIV_CYCLES` if `md_is_div_e`, else `MULT_CYCLES`.
- Otherwise, if `md_cnt` ≠ 0: decrement by 1.
- A start while busy is a protocol violation. The required behaviour is a reload; no error is flagged.
- `md_busy` = (`md_cnt` ≠ 0). It is registered-derived.

**MD hazard.** `md_hz` = `md_d` & (`md_busy` | `md_start_e`).

**Outputs.**
- `stall` = `data_hz` | `md_hz`.
- `stall_cause` = {`md_hz`, `data_hz`}. Both bits may be set together.

**Stall counter.**
- Increments by 1 on each rising edge where `stall` = 1.
- Holds at all-ones (saturates).
- Never wraps.

**Reset.** Sets `md_cnt` = 0 and `stall_cnt` = 0. A reset mid-division discards the remaining busy time.

## Timing
- `stall`, `stall_cause`: combinational from the inputs and `md_cnt`, valid in the same cycle; no latency added by this block.
- `md_busy`, `stall_cnt`: registered.
- Reset values:
  - `md_busy` = 0 and `stall_cnt` = 0 in the cycle after reset is sampled.
  - `stall` and `stall_cause` follow the inputs; they are 0 with all-zero inputs.
- Start sampled at edge T (E cycle T-1 → edge T): `md_busy` = 1 for exactly N cycles after edge T (N = MULT_CYCLES or DIV_CYCLES), then 0.
- An MD instruction in D during the start cycle stalls via `md_start_e`. It then stalls through all N busy cycles and issues in the first cycle with `md_busy` = 0.
- Reset asserted together with `md_start_e`: reset wins, `md_cnt` = 0.
- `stall_cnt` counts cycles with `stall` = 1 in the same cycle as reset: not counted.
- Tuse all-ones (7) with Tnew ≤ 2: never stalls.

## Test plan
- **Load-use.** `type_e` = load, `we_e` = 1, `a3_e` = 5, `a1_d` = 5, `tuse_rs_d` = 1 → `stall` = 1, `stall_cause` = 2'b01. Same stimulus with `tuse_rs_d` = 2 → `stall` = 0.
- **Register-0 and M-stage.**
  - `a3_m` = 0, `a2_d` = 0, `type_m` = load, `tuse_rt_d` = 0 → `stall` = 0.
  - Same with `a3_m` = `a2_d` = 9 → `stall` = 1.
  - Same with `type_m` = calc → `stall` = 0.
- **Multiply.** Pulse `md_start_e` (mult) one cycle, hold `md_d` = 1 → `stall` = 1 in the start cycle plus 5 following cycles (6 total), `stall_cause` = 2'b10. `md_busy` is high for exactly 5 cycles. `stall_cnt` = 6 afterwards.
- **Divide, then reset mid-operation.** Start div, assert `reset` after 4 busy cycles → next cycle `md_busy` = 0, `stall_cnt` = 0, and `md_d` = 1 no longer stalls.
- **Combined causes.** Load hazard on rs plus `md_d` while busy → `stall_cause` = 2'b11.
- **Saturation.** With `CNT_W` = 3, hold `stall` = 1 for 10 cycles → `stall_cnt` reads 1, 2, …, 7 and then stays at 7.
